// File: rtl/pocket_core_pkg.sv
// Shared definitions for the pocket core reset sequencer:
// FSM state encodings, default timing parameters and small helpers.
package pocket_core_pkg;

   // Sequencer FSM states; the encoding is visible on the state output.
   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_STABLE    = 2'd1,
      ST_RELEASE   = 2'd2,
      ST_RUN       = 2'd3
   } seq_state_e;

   // Default timing: lock qualification, reset staging and pixel enable ratio.
   localparam int unsigned DEF_STABLE_CYCLES = 32'd4096;
   localparam int unsigned DEF_STAGE_CYCLES  = 32'd256;
   localparam int unsigned DEF_CE_DIV        = 32'd8;

   // Width of a counter that must reach max(a, b) - 1 without wrapping.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      if (m <= 32'd2) begin
         return 32'd1;
      end else begin
         return $clog2(m);
      end
   endfunction

   // Saturating 8-bit increment, sticks at 255.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) begin
         return 8'hFF;
      end else begin
         return v + 8'h01;
      end
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Status bundle of the PLL reset sequencer: staged resets, pixel enable,
// ready flag and FSM state. The master side is the sequencer, the slave
// side is any consumer (core, CPU, monitor).
// Optional macro PLL_RESET_LOSS_COUNT_EN adds the lock_loss_count field.
interface pll_reset_sequencer_if;

   logic       core_reset_n;
   logic       cpu_reset_n;
   logic       ce_pix;
   logic       ready;
   logic [1:0] state;
`ifdef PLL_RESET_LOSS_COUNT_EN
   logic [7:0] lock_loss_count;

   modport master (
      output core_reset_n,
      output cpu_reset_n,
      output ce_pix,
      output ready,
      output state,
      output lock_loss_count
   );

   modport slave (
      input  core_reset_n,
      input  cpu_reset_n,
      input  ce_pix,
      input  ready,
      input  state,
      input  lock_loss_count
   );
`else
   modport master (
      output core_reset_n,
      output cpu_reset_n,
      output ce_pix,
      output ready,
      output state
   );

   modport slave (
      input  core_reset_n,
      input  cpu_reset_n,
      input  ce_pix,
      input  ready,
      input  state
   );
`endif

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Output lags the input by two clk edges; both stages clear on reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   // Next values of the two capture stages.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Capture stages, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: waits for a stable PLL lock, releases the core reset,
// then the CPU reset, and generates a 1-in-CE_DIV pixel clock enable while
// the core is out of reset. Lock loss or user_reset aborts to WAIT_LOCK.
// Optional macro PLL_RESET_LOSS_COUNT_EN adds an 8-bit saturating count of
// lock losses seen in RELEASE or RUN (output lock_loss_count).
module pll_reset_sequencer
   import pocket_core_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned STAGE_CYCLES  = DEF_STAGE_CYCLES,
   parameter int unsigned CE_DIV        = DEF_CE_DIV          // must be >= 2
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       pll_locked,
   input  logic       user_reset,
   output logic       core_reset_n,
   output logic       cpu_reset_n,
   output logic       ce_pix,
   output logic       ready,
   output logic [1:0] state
`ifdef PLL_RESET_LOSS_COUNT_EN
   ,
   output logic [7:0] lock_loss_count
`endif
);

   localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES, STAGE_CYCLES);
   localparam int unsigned DIV_W = $clog2(CE_DIV);

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_CYCLES - 32'd1);
   localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(32'd1);
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CE_DIV - 32'd1);

   logic             locked_s;
   logic             abort_s;

   seq_state_e       state_q;
   seq_state_e       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             core_q;
   logic             core_d;
   logic             cpu_q;
   logic             cpu_d;
   logic             rdy_q;
   logic             rdy_d;
   logic             ce_q;
   logic             ce_d;

   // PLL lock crosses into clk_sys through its own synchronizer.
   sync_2ff u_lock_sync (
      .clk   (clk_sys),
      .rst_n (reset_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   // Lock loss and user request both force the sequence back to the start.
   assign abort_s = (~locked_s) | user_reset;

   // Next state and cycle counter; abort overrides every other transition.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (abort_s) begin
         state_d = ST_WAIT_LOCK;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_WAIT_LOCK: begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end
            ST_STABLE: begin
               if (cnt_q == STABLE_LAST) begin
                  state_d = ST_RELEASE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_RELEASE: begin
               if (cnt_q == STAGE_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_RUN: begin
               cnt_d = '0;
            end
            default: begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Reset outputs follow the state being entered, so they drop on the abort edge.
   always_comb begin
      core_d = (state_d == ST_RELEASE) || (state_d == ST_RUN);
      cpu_d  = (state_d == ST_RUN);
      rdy_d  = (state_d == ST_RUN);
   end

   // Pixel divider runs only while the core stays out of reset; it starts
   // from 0 on the release edge so the first pulse lands CE_DIV cycles later.
   always_comb begin
      div_d = '0;
      ce_d  = 1'b0;
      if (core_d && core_q) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            ce_d  = 1'b1;
         end else begin
            div_d = div_q + DIV_ONE;
            ce_d  = 1'b0;
         end
      end else begin
         div_d = '0;
         ce_d  = 1'b0;
      end
   end

   // State, counter, divider and registered outputs.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_WAIT_LOCK;
         cnt_q   <= '0;
         div_q   <= '0;
         core_q  <= 1'b0;
         cpu_q   <= 1'b0;
         rdy_q   <= 1'b0;
         ce_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         core_q  <= core_d;
         cpu_q   <= cpu_d;
         rdy_q   <= rdy_d;
         ce_q    <= ce_d;
      end
   end

   assign core_reset_n = core_q;
   assign cpu_reset_n  = cpu_q;
   assign ready        = rdy_q;
   assign ce_pix       = ce_q;
   assign state        = state_q;

`ifdef PLL_RESET_LOSS_COUNT_EN
   logic       loss_s;
   logic [7:0] loss_q;
   logic [7:0] loss_d;

   // Only a real lock loss after the core was released counts; user aborts do not.
   always_comb begin
      loss_s = (~locked_s) && ((state_q == ST_RELEASE) || (state_q == ST_RUN));
      if (loss_s) begin
         loss_d = sat_inc8(loss_q);
      end else begin
         loss_d = loss_q;
      end
   end

   // Lock loss counter register.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         loss_q <= 8'd0;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign lock_loss_count = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer (STABLE=16, STAGE=4, CE_DIV=8).
// The reference model tracks how many consecutive edges the synchronized lock
// has been good and derives state, resets, ready, ce_pix and the loss count
// from that run length.
module tb_pll_reset_sequencer;

   localparam int S = 16;
   localparam int T = 4;
   localparam int D = 8;

   logic clk_sys;
   logic reset_n;
   logic pll_locked;
   logic user_reset;

   int   total   = 0;
   int   bad     = 0;
   int   cyc     = 0;
   int   run_len = 0;
   int   loss_m  = 0;
   logic h1      = 1'b0;
   logic h2      = 1'b0;

   pll_reset_sequencer_if bus ();

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   pll_reset_sequencer #(
      .STABLE_CYCLES (S),
      .STAGE_CYCLES  (T),
      .CE_DIV        (D)
   ) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .pll_locked   (pll_locked),
      .user_reset   (user_reset),
      .core_reset_n (bus.core_reset_n),
      .cpu_reset_n  (bus.cpu_reset_n),
      .ce_pix       (bus.ce_pix),
      .ready        (bus.ready),
      .state        (bus.state)
`ifdef PLL_RESET_LOSS_COUNT_EN
      ,
      .lock_loss_count (bus.lock_loss_count)
`endif
   );

`ifdef PLL_RESET_LOSS_COUNT_EN
   wire [7:0] loss_act = bus.lock_loss_count;
`else
   wire [7:0] loss_act = 8'd0;
`endif

   wire [13:0] actv = {bus.state, bus.core_reset_n, bus.cpu_reset_n, bus.ready, bus.ce_pix, loss_act};

   // One clock edge of the reference model; returns 1 time unit after the edge.
   task automatic tick();
      logic ls;
      @(posedge clk_sys);
      if (reset_n !== 1'b1) begin
         h1 = 1'b0; h2 = 1'b0; run_len = 0; loss_m = 0;
      end else begin
         ls = h2;
         if (!ls && run_len > S && loss_m < 255) loss_m++;
         if (ls && !user_reset) begin
            if (run_len < 1000000) run_len++;
         end else begin
            run_len = 0;
         end
         h2 = h1;
         h1 = pll_locked;
      end
      cyc++;
      #1;
   endtask

   // Expected {state, core_reset_n, cpu_reset_n, ready, ce_pix, loss} from the run length.
   function automatic logic [13:0] expv();
      logic [1:0] st;
      logic       core;
      logic       cpu;
      logic       ce;
      logic [7:0] l;
      if (run_len == 0)          st = 2'd0;
      else if (run_len <= S)     st = 2'd1;
      else if (run_len <= S + T) st = 2'd2;
      else                       st = 2'd3;
      core = (run_len > S);
      cpu  = (run_len > S + T);
      ce   = core && ((run_len - S - 1) >= D) && (((run_len - S - 1) % D) == 0);
`ifdef PLL_RESET_LOSS_COUNT_EN
      l = loss_m[7:0];
`else
      l = 8'd0;
`endif
      return {st, core, cpu, cpu, ce, l};
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; pll_locked = 1'b1; user_reset = 1'b0;
      #2;
      total++;
      if (actv !== 14'd0) begin bad++; $display("FAIL reset_initial got=%h want=%h", actv, 14'd0); end
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (actv !== 14'd0) begin bad++; $display("FAIL reset_hold cyc=%0d got=%h want=%h", cyc, actv, 14'd0); end
      end
      reset_n = 1'b1;
   endtask

   task automatic test_lock_sequence();
      int core_at = -1;
      int cpu_at  = -1;
      int ce_at   = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         total++;
         if (actv !== expv()) begin bad++; $display("FAIL seq cyc=%0d got=%h want=%h", cyc, actv, expv()); end
         if (core_at < 0 && bus.core_reset_n === 1'b1) core_at = k;
         if (cpu_at < 0 && bus.cpu_reset_n === 1'b1 && bus.ready === 1'b1) cpu_at = k;
         if (ce_at < 0 && bus.ce_pix === 1'b1) ce_at = k;
      end
      total++;
      if (core_at < S + 2 || core_at > S + 3) begin bad++; $display("FAIL seq_core_time got=%0d want=%0d..%0d", core_at, S + 2, S + 3); end
      total++;
      if (cpu_at < S + T + 1 || cpu_at > S + T + 3) begin bad++; $display("FAIL seq_cpu_time got=%0d want=%0d..%0d", cpu_at, S + T + 1, S + T + 3); end
      total++;
      if (ce_at - core_at != D) begin bad++; $display("FAIL seq_first_ce got=%0d want=%0d", ce_at - core_at, D); end
   endtask

   task automatic test_stable_glitch();
      int lb;
      int core_at  = -1;
      bit saw_wait = 1'b0;
      pll_locked = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); total++;
         if (actv !== expv()) begin bad++; $display("FAIL glitch_drop cyc=%0d got=%h want=%h", cyc, actv, expv()); end
      end
      pll_locked = 1'b1;
      for (int i = 0; i < 40 && run_len != 11; i++) begin
         tick(); total++;
         if (actv !== expv()) begin bad++; $display("FAIL glitch_climb cyc=%0d got=%h want=%h", cyc, actv, expv()); end
      end
      total++;
      if (run_len != 11) begin bad++; $display("FAIL glitch_reach_count10 got=%0d want=%0d", run_len, 11); end
      lb = loss_m;
      pll_locked = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); total++;
         if (actv !== expv()) begin bad++; $display("FAIL glitch_low cyc=%0d got=%h want=%h", cyc, actv, expv()); end
         if (bus.state === 2'd0) saw_wait = 1'b1;
      end
      pll_locked = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick(); total++;
         if (actv !== expv()) begin bad++; $display("FAIL glitch_restart cyc=%0d got=%h want=%h", cyc, actv, expv()); end
         if (bus.state === 2'd0) saw_wait = 1'b1;
         if (core_at < 0 && bus.core_reset_n === 1'b1) core_at = k;
      end
      total++;
      if (saw_wait !== 1'b1) begin bad++; $display("FAIL glitch_wait_lock got=%0d want=%0d", saw_wait, 1); end
      total++;
      if (core_at != S + 3) begin bad++; $display("FAIL glitch_full_restart got=%0d want=%0d", core_at, S + 3); end
`ifdef PLL_RESET_LOSS_COUNT_EN
      total++;
      if (loss_act !== 8'(lb)) begin bad++; $display("FAIL glitch_loss_count got=%0d want=%0d", loss_act, lb); end
`endif
      // Sub-cycle dips between edges never reach locked_s.
      for (int i = 0; i < 6; i++) begin
         #2 pll_locked = 1'b0;
         #3 pll_locked = 1'b1;
         tick(); total++;
         if (bus.state !== 2'd3 || actv !== expv()) begin bad++; $display("FAIL short_glitch cyc=%0d got=%h want=%h", cyc, actv, expv()); end
      end
   endtask

   task automatic test_lock_loss_run();
      int lb;
      for (int i = 0; i < 60 && run_len <= S + T; i++) begin
         tick(); total++;
         if (actv !== expv()) begin bad++; $display("FAIL loss_wait cyc=%0d got=%h want=%h", cyc, actv, expv()); end
      end
      total++;
      if (run_len <= S + T) begin bad++; $display("FAIL loss_wait_timeout got=%0d want=>%0d", run_len, S + T); end
      lb = loss_m;
      pll_locked = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); total++;
         if (actv !== expv()) begin bad++; $display("FAIL loss_drop cyc=%0d got=%h want=%h", cyc, actv, expv()); end
      end
      total++;
      if ({bus.core_reset_n, bus.cpu_reset_n, bus.ready} !== 3'b000) begin
         bad++; $display("FAIL loss_resets_low got=%b want=%b", {bus.core_reset_n, bus.cpu_reset_n, bus.ready}, 3'b000);
      end
`ifdef PLL_RESET_LOSS_COUNT_EN
      total++;
      if (loss_act !== 8'((lb < 255) ? lb + 1 : 255)) begin bad++; $display("FAIL loss_count_inc got=%0d want=%0d", loss_act, lb + 1); end
`endif
      for (int i = 0; i < 10; i++) begin
         tick(); total++;
         if (bus.ce_pix !== 1'b0 || actv !== expv()) begin bad++; $display("FAIL loss_ce_stopped cyc=%0d got=%h want=%h", cyc, actv, expv()); end
      end
      pll_locked = 1'b1;
   endtask

   task automatic test_user_reset();
      int lb;
      int rdy_at = -1;
      for (int i = 0; i < 60 && run_len <= S + T; i++) begin
         tick(); total++;
         if (actv !== expv()) begin bad++; $display("FAIL user_wait cyc=%0d got=%h want=%h", cyc, actv, expv()); end
      end
      total++;
      if (run_len <= S + T) begin bad++; $display("FAIL user_wait_timeout got=%0d want=>%0d", run_len, S + T); end
      lb = loss_m;
      user_reset = 1'b1;
      tick();
      user_reset = 1'b0;
      total++;
      if ({bus.state, bus.core_reset_n, bus.cpu_reset_n, bus.ready} !== 5'd0) begin
         bad++; $display("FAIL user_abort got=%b want=%b", {bus.state, bus.core_reset_n, bus.cpu_reset_n, bus.ready}, 5'd0);
      end
      for (int k = 1; k <= 30; k++) begin
         tick(); total++;
         if (actv !== expv()) begin bad++; $display("FAIL user_replay cyc=%0d got=%h want=%h", cyc, actv, expv()); end
         if (rdy_at < 0 && bus.ready === 1'b1) rdy_at = k;
      end
      total++;
      if (rdy_at != S + T + 1) begin bad++; $display("FAIL user_replay_time got=%0d want=%0d", rdy_at, S + T + 1); end
`ifdef PLL_RESET_LOSS_COUNT_EN
      total++;
      if (loss_act !== 8'(lb)) begin bad++; $display("FAIL user_loss_count got=%0d want=%0d", loss_act, lb); end
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if (pll_locked) pll_locked = ($urandom_range(0, 99) >= 2);
         else            pll_locked = ($urandom_range(0, 99) < 25);
         user_reset = ($urandom_range(0, 99) < 2);
         tick(); total++;
         if (actv !== expv()) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, actv, expv()); end
      end
      pll_locked = 1'b1;
      user_reset = 1'b0;
   endtask

   task automatic test_saturate();
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 60 && run_len <= S + T; i++) begin
            tick(); total++;
            if (actv !== expv()) begin bad++; $display("FAIL sat_wait cyc=%0d got=%h want=%h", cyc, actv, expv()); end
         end
         total++;
         if (run_len <= S + T) begin bad++; $display("FAIL sat_wait_timeout n=%0d got=%0d want=>%0d", n, run_len, S + T); end
         pll_locked = 1'b0;
         for (int i = 0; i < 3; i++) begin
            tick(); total++;
            if (actv !== expv()) begin bad++; $display("FAIL sat_drop cyc=%0d got=%h want=%h", cyc, actv, expv()); end
         end
         pll_locked = 1'b1;
      end
`ifdef PLL_RESET_LOSS_COUNT_EN
      total++;
      if (loss_act !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d want=%0d", loss_act, 255); end
`endif
   endtask

   task automatic test_async_reset();
      int core_at = -1;
      for (int i = 0; i < 40 && run_len != S + 2; i++) begin
         tick(); total++;
         if (actv !== expv()) begin bad++; $display("FAIL areset_wait cyc=%0d got=%h want=%h", cyc, actv, expv()); end
      end
      total++;
      if (run_len != S + 2 || bus.state !== 2'd2) begin bad++; $display("FAIL areset_in_release got=%0d want=%0d", bus.state, 2); end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (actv !== 14'd0) begin bad++; $display("FAIL areset_immediate got=%h want=%h", actv, 14'd0); end
      for (int i = 0; i < 3; i++) begin
         tick(); total++;
         if (actv !== expv()) begin bad++; $display("FAIL areset_hold cyc=%0d got=%h want=%h", cyc, actv, expv()); end
      end
      reset_n = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick(); total++;
         if (actv !== expv()) begin bad++; $display("FAIL areset_replay cyc=%0d got=%h want=%h", cyc, actv, expv()); end
         if (core_at < 0 && bus.core_reset_n === 1'b1) core_at = k;
      end
      total++;
      if (core_at < S + 2) begin bad++; $display("FAIL areset_early_release got=%0d want=>=%0d", core_at, S + 2); end
   endtask

   initial begin
      test_reset();
      test_lock_sequence();
      test_stable_glitch();
      test_lock_loss_run();
      test_user_reset();
      test_random();
      test_saturate();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
